// File: rtl/decode_stage.sv
// RV32I decode / register-read stage: register file, operand select, load-use stall.
// Optional macro DECODE_ILLEGAL_EN flags unknown opcodes / bad R-type funct7.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instr_in,
    input  logic [31:0]     pc_in,
    input  logic            instr_valid,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] d1_out,
    output logic [XLEN-1:0] d2_out,
    output logic [31:0]     c_d_e_out,
    output logic [31:0]     pc_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [XLEN-1:0] br_imm_out,
    output logic            stall_out,
    output logic            illegal_out
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [XLEN-1:0] r_rf [NREGS];
    logic [4:0]      r_ld_rd;
    logic            r_illegal;

    logic [6:0]      w_op;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_d1;
    logic [XLEN-1:0] w_d2;
    logic [XLEN-1:0] w_st;
    logic [XLEN-1:0] w_br;
    logic [4:0]      w_rdf;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_known;
    logic            w_use1;
    logic            w_use2;
    logic            w_hit;
    logic            w_illegal;
    logic            w_issue;

    assign w_op  = instr_in[6:0];
    assign w_rd  = instr_in[11:7];
    assign w_rs1 = instr_in[19:15];
    assign w_rs2 = instr_in[24:20];

    assign w_imm_i = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
    assign w_imm_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign w_imm_b = {{(XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7],
                      instr_in[30:25], instr_in[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-21){instr_in[31]}}, instr_in[31], instr_in[19:12],
                      instr_in[20], instr_in[30:21], 1'b0};

    // Register file write port; x0 is never written
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            r_rf[wb_rd] <= wb_data;
        end
    end

    // Read ports with write-before-read bypass from writeback
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != 5'd0)
            w_rs1_val = (wb_en && wb_rd == w_rs1) ? wb_data : r_rf[w_rs1];
        if (w_rs2 != 5'd0)
            w_rs2_val = (wb_en && wb_rd == w_rs2) ? wb_data : r_rf[w_rs2];
    end

    // Opcode decode: operands, offsets, control fields and source usage
    always_comb begin
        w_d1    = '0;
        w_d2    = '0;
        w_st    = '0;
        w_br    = '0;
        w_rdf   = w_rd;
        w_f3    = instr_in[14:12];
        w_f7    = '0;
        w_known = 1'b1;
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        case (w_op)
            OP_R: begin
                w_d1   = w_rs1_val;
                w_d2   = w_rs2_val;
                w_f7   = instr_in[31:25];
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            OP_IMM, OP_LOAD: begin
                w_d1   = w_rs1_val;
                w_d2   = w_imm_i;
                w_use1 = 1'b1;
            end
            OP_JALR: begin
                w_d1   = w_rs1_val;
                w_d2   = w_imm_i;
                w_br   = w_imm_i;
                w_use1 = 1'b1;
            end
            OP_STORE: begin
                w_d1   = w_rs1_val;
                w_d2   = w_imm_s;
                w_st   = w_rs2_val;
                w_rdf  = '0;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            OP_BR: begin
                w_d1   = w_rs1_val;
                w_d2   = w_rs2_val;
                w_br   = w_imm_b;
                w_rdf  = '0;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            OP_JAL: begin
                w_br = w_imm_j;
                w_f3 = '0;
            end
            OP_LUI, OP_AUIPC: begin
                w_d2 = {{(XLEN-20){1'b0}}, instr_in[31:12]};
                w_f3 = '0;
            end
            default: w_known = 1'b0;
        endcase
    end

    // Load-use: the load issued last cycle writes a register this one reads
    assign w_hit = instr_valid && r_ld_rd != 5'd0 &&
                   ((w_use1 && w_rs1 == r_ld_rd) ||
                    (w_use2 && w_rs2 == r_ld_rd));

    assign stall_out = w_hit && !flush && !reset;

`ifdef DECODE_ILLEGAL_EN
    logic w_f7_ok;
    assign w_f7_ok   = (w_op != OP_R) ||
                       instr_in[31:25] == 7'b0000000 ||
                       instr_in[31:25] == 7'b0100000;
    assign w_illegal = instr_valid && !w_hit && (!w_known || !w_f7_ok);
    assign w_issue   = instr_valid && !w_hit && w_known && w_f7_ok;
`else
    assign w_illegal = 1'b0;
    assign w_issue   = instr_valid && !w_hit && w_known;
`endif

    // Output register: issue decoded instruction or insert a bubble
    always_ff @(posedge clock) begin
        if (reset || flush || !w_issue) begin
            d1_out         <= '0;
            d2_out         <= '0;
            c_d_e_out      <= '0;
            store_data_out <= '0;
            br_imm_out     <= '0;
            r_ld_rd        <= '0;
            r_illegal      <= !reset && !flush && w_illegal;
            pc_out         <= (!reset && !flush && w_illegal) ? pc_in : '0;
        end else begin
            d1_out         <= w_d1;
            d2_out         <= w_d2;
            c_d_e_out      <= {10'b0, w_rdf, w_f7, w_f3, w_op};
            store_data_out <= w_st;
            br_imm_out     <= w_br;
            r_ld_rd        <= (w_op == OP_LOAD) ? w_rdf : 5'd0;
            r_illegal      <= 1'b0;
            pc_out         <= pc_in;
        end
    end

    assign illegal_out = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
// Expected values are hand-encoded RV32I fields.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic        instr_valid = 1'b0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] d1_out;
    logic [31:0] d2_out;
    logic [31:0] c_d_e_out;
    logic [31:0] pc_out;
    logic [31:0] store_data_out;
    logic [31:0] br_imm_out;
    logic        stall_out;
    logic        illegal_out;

    int n_checks = 0;
    int n_pass   = 0;

    decode_stage dut (
        .clock          (clock),
        .reset          (reset),
        .instr_in       (instr_in),
        .pc_in          (pc_in),
        .instr_valid    (instr_valid),
        .flush          (flush),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .d1_out         (d1_out),
        .d2_out         (d2_out),
        .c_d_e_out      (c_d_e_out),
        .pc_out         (pc_out),
        .store_data_out (store_data_out),
        .br_imm_out     (br_imm_out),
        .stall_out      (stall_out),
        .illegal_out    (illegal_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        instr_in    = ins;
        pc_in       = pc;
        instr_valid = 1'b1;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        instr_valid = 1'b0;
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
        tick();
        wb_en   = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_d1", d1_out, 32'h0);
        chk("rst_d2", d2_out, 32'h0);
        chk("rst_cde", c_d_e_out, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_ill", {31'b0, illegal_out}, 32'h0);
        chk("rst_stall", {31'b0, stall_out}, 32'h0);
        reset = 1'b0;

        // addi x1,x0,5
        drive(32'h00500093, 32'h0);
        tick();
        chk("addi_d1", d1_out, 32'h0);
        chk("addi_d2", d2_out, 32'h5);
        chk("addi_cde", c_d_e_out, 32'h00020013);
        chk("addi_pc", pc_out, 32'h0);

        // preload x1=7, x2=9; x0 write must be ignored
        wb(5'd1, 32'd7);
        wb(5'd2, 32'd9);
        wb(5'd0, 32'hDEADBEEF);
        chk("inv_cde", c_d_e_out, 32'h0);

        // add x3,x1,x2
        drive(32'h002081B3, 32'h4);
        tick();
        chk("add_d1", d1_out, 32'd7);
        chk("add_d2", d2_out, 32'd9);
        chk("add_cde", c_d_e_out, 32'h00060033);
        chk("add_pc", pc_out, 32'h4);
        chk("add_st", store_data_out, 32'h0);

        // add x4,x0,x0 : x0 reads zero
        drive(32'h00000233, 32'h8);
        tick();
        chk("x0_d1", d1_out, 32'h0);
        chk("x0_cde", c_d_e_out, 32'h00080033);

        // sw x2,-4(x1) with same-cycle writeback of x1
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        drive(32'hFE20AE23, 32'hC);
        tick();
        wb_en = 1'b0;
        chk("sw_d1", d1_out, 32'h55);
        chk("sw_d2", d2_out, 32'hFFFFFFFC);
        chk("sw_st", store_data_out, 32'd9);
        chk("sw_cde", c_d_e_out, 32'h00000123);

        // lw x5,8(x1) then add x6,x5,x5 : one-cycle stall
        drive(32'h0080A283, 32'h10);
        tick();
        chk("lw_d1", d1_out, 32'h55);
        chk("lw_d2", d2_out, 32'h8);
        chk("lw_cde", c_d_e_out, 32'h000A0103);
        drive(32'h00528333, 32'h14);
        #1;
        chk("lu_stall", {31'b0, stall_out}, 32'h1);
        tick();
        chk("lu_bub", c_d_e_out, 32'h0);
        chk("lu_stall2", {31'b0, stall_out}, 32'h0);
        tick();
        chk("lu_cde", c_d_e_out, 32'h000C0033);
        chk("lu_pc", pc_out, 32'h14);

        // lw x5 then addi x6,x0,5 : rs2 field equals 5 but is unused
        drive(32'h0080A283, 32'h18);
        tick();
        drive(32'h00500313, 32'h1C);
        #1;
        chk("nohz_stall", {31'b0, stall_out}, 32'h0);
        tick();
        chk("nohz_cde", c_d_e_out, 32'h000C0013);

        // lui with flush, then without
        drive(32'h123453B7, 32'h20);
        flush = 1'b1;
        #1;
        chk("fl_stall", {31'b0, stall_out}, 32'h0);
        tick();
        chk("fl_cde", c_d_e_out, 32'h0);
        chk("fl_d2", d2_out, 32'h0);
        flush = 1'b0;
        tick();
        chk("lui_d1", d1_out, 32'h0);
        chk("lui_d2", d2_out, 32'h00012345);

        // flush wins over load-use stall
        drive(32'h0080A283, 32'h24);
        tick();
        drive(32'h00528333, 32'h28);
        flush = 1'b1;
        #1;
        chk("flst_stall", {31'b0, stall_out}, 32'h0);
        tick();
        flush = 1'b0;
        chk("flst_cde", c_d_e_out, 32'h0);

        // reset in the middle of a stall
        drive(32'h0080A283, 32'h2C);
        tick();
        drive(32'h00528333, 32'h30);
        #1;
        chk("rs_stall1", {31'b0, stall_out}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rs_stall0", {31'b0, stall_out}, 32'h0);
        tick();
        chk("rs_cde", c_d_e_out, 32'h0);
        reset = 1'b0;

        // register file cleared by reset
        drive(32'h002081B3, 32'h34);
        tick();
        chk("rfclr_d1", d1_out, 32'h0);
        chk("rfclr_d2", d2_out, 32'h0);

        wb(5'd1, 32'd3);
        wb(5'd2, 32'hFFFFFFF0);

        // beq x1,x2,+8
        drive(32'h00208463, 32'h38);
        tick();
        chk("beq_d1", d1_out, 32'd3);
        chk("beq_d2", d2_out, 32'hFFFFFFF0);
        chk("beq_br", br_imm_out, 32'h8);
        chk("beq_cde", c_d_e_out, 32'h00000063);

        // beq x0,x0,-4
        drive(32'hFE000EE3, 32'h3C);
        tick();
        chk("beqn_br", br_imm_out, 32'hFFFFFFFC);

        // jal x0,+0x800 (imm[11] only)
        drive(32'h0010006F, 32'h40);
        tick();
        chk("jal_br", br_imm_out, 32'h00000800);
        chk("jal_d1", d1_out, 32'h0);
        chk("jal_cde", c_d_e_out, 32'h0000006F);

        // jal x1,-2
        drive(32'hFFFFF0EF, 32'h44);
        tick();
        chk("jaln_br", br_imm_out, 32'hFFFFFFFE);

        // jalr x1,16(x1)
        drive(32'h010080E7, 32'h48);
        tick();
        chk("jalr_d1", d1_out, 32'd3);
        chk("jalr_d2", d2_out, 32'd16);
        chk("jalr_br", br_imm_out, 32'd16);
        chk("jalr_cde", c_d_e_out, 32'h00020067);

        // srai x1,x1,3 : raw immediate keeps funct7
        drive(32'h4030D093, 32'h4C);
        tick();
        chk("srai_d2", d2_out, 32'h00000403);
        chk("srai_cde", c_d_e_out, 32'h00020293);
        chk("srai_br", br_imm_out, 32'h0);

        // sub x3,x1,x2
        drive(32'h402081B3, 32'h50);
        tick();
        chk("sub_cde", c_d_e_out, 32'h00068033);

        // unknown opcode 0x7F at pc 0x40
        drive(32'h0000007F, 32'h40);
        tick();
        chk("ill_cde", c_d_e_out, 32'h0);
`ifdef DECODE_ILLEGAL_EN
        chk("ill_flag", {31'b0, illegal_out}, 32'h1);
        chk("ill_pc", pc_out, 32'h40);
`else
        chk("ill_flag", {31'b0, illegal_out}, 32'h0);
        chk("ill_pc", pc_out, 32'h0);
`endif

        // R-type with funct7 0000001
        drive(32'h022081B3, 32'h54);
        tick();
`ifdef DECODE_ILLEGAL_EN
        chk("f7_cde", c_d_e_out, 32'h0);
        chk("f7_flag", {31'b0, illegal_out}, 32'h1);
`else
        chk("f7_cde", c_d_e_out, 32'h00060433);
        chk("f7_flag", {31'b0, illegal_out}, 32'h0);
`endif

        // invalid slot is a bubble
        instr_valid = 1'b0;
        tick();
        chk("end_cde", c_d_e_out, 32'h0);
        chk("end_ill", {31'b0, illegal_out}, 32'h0);
        chk("end_pc", pc_out, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
